register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
//
// PURPOSE
// Parametrised multi-read, dual-write CPU register file with integrated scoreboard.
// Write port 0 takes in-order pipeline writeback; write port 1 takes late results (loads/muldiv) and retires busy bits.
// Optional same-cycle write-to-read bypass.
// Per-register busy bits let issue logic stall on RAW hazards against outstanding long-latency ops.
//
// PARAMETERS
// DATA_WIDTH     32  width of each register
// ADDR_WIDTH     5   register index width; depth = 2**ADDR_WIDTH
// NUM_READ_PORTS 2   independent combinational read ports (1..4)
// BYPASS         1   1: reads see same-cycle writes; 0: writes visible next cycle
// ZERO_REG       1   1: register 0 hardwired to zero, never busy
//
// PORTS
// clk           in   1                          clock, all state updates on posedge
// reset         in   1                          asynchronous, active-high
// rd_addr       in   NUM_READ_PORTS*ADDR_WIDTH  packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
// rd_data       out  NUM_READ_PORTS*DATA_WIDTH  packed read data, same packing
// rd_busy       out  NUM_READ_PORTS             port p's register has an outstanding reservation
// wr0_en        in   1                          pipeline writeback enable
// wr0_addr      in   ADDR_WIDTH                 pipeline writeback index
// wr0_data      in   DATA_WIDTH                 pipeline writeback data
// wr1_en        in   1                          late-result write enable; also releases busy
// wr1_addr      in   ADDR_WIDTH                 late-result index
// wr1_data      in   DATA_WIDTH                 late-result data
// rsv_en        in   1                          reserve (set busy) for rsv_addr
// rsv_addr      in   ADDR_WIDTH                 index to reserve
// flush         in   1                          clear all busy bits; data untouched
// busy_count    out  ADDR_WIDTH+1               number of busy registers (registered)
//
// BEHAVIOUR
// - Reset (async, reset=1): all registers <= 0, all busy bits <= 0, busy_count <= 0.
//   rd_data reads 0 and rd_busy reads 0 while reset is held.
// - Reset mid-operation discards pending reservations; late wr1 after reset still writes data, busy stays 0.
// - Writes, posedge clk:
//   - wr0_en writes regs[wr0_addr].
//   - wr1_en writes regs[wr1_addr].
//   - Same address on both ports: wr0 data wins; wr1 still releases busy.
//   - ZERO_REG=1: writes, reservations and releases to index 0 are ignored.
// - Reads: combinational from rd_addr; no clock latency.
//   - BYPASS=1 priority: wr0 data (if addr match) > wr1 data (if match) > stored value.
//   - BYPASS=0: stored value only; write visible the cycle after.
//   - ZERO_REG=1 and addr 0: data = 0, busy = 0 regardless of writes.
// - Busy bit b[i], posedge clk:
//   - rsv_en && rsv_addr==i -> 1.
//   - else wr1_en && wr1_addr==i -> 0.
//   - Reserve and release of same index same cycle: reserve wins (back-to-back ops), b stays 1.
//   - flush=1: all b <= 0, overrides rsv_en and wr1 in that cycle.
//   - Reserving an already-busy register: no change.
//   - Releasing a non-busy register: data written, b stays 0.
//   - wr0 never affects busy bits.
// - rd_busy[p]:
//   - BYPASS=1: b[rd_addr_p] & ~(wr1_en && wr1_addr==rd_addr_p) — a same-cycle release is seen as ready.
//   - BYPASS=0: b[rd_addr_p].
//   - A same-cycle rsv_en is NOT reflected until the next cycle.
// - busy_count: popcount of b after each update, registered; range 0..2**ADDR_WIDTH
//   (2**ADDR_WIDTH-1 if ZERO_REG=1).
//
// TESTING
// 1. Reset then read all 32 indices on both ports -> every rd_data=0, rd_busy=0, busy_count=0.
// 2. wr0 x5=0xDEADBEEF, read x5 same cycle: BYPASS=1 -> 0xDEADBEEF immediately; BYPASS=0 -> old 0, then 0xDEADBEEF next cycle.
// 3. wr0 x7=1 and wr1 x7=2 same cycle -> x7 reads 1 afterwards; busy[7] cleared; wr0 x0=0x55 -> x0 reads 0.
// 4. rsv x3 -> next cycle rd_busy=1, busy_count=1; wr1 x3=0x1234 -> same cycle rd_busy=0 (BYPASS=1), data 0x1234; busy_count=0.
// 5. rsv x9 and wr1 x9 same cycle with x9 busy -> x9 remains busy, busy_count unchanged; flush -> busy_count=0 next cycle.
// 6. rsv x4,x6, assert reset asynchronously mid-cycle -> busy/count/data clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/register_file_sb.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
// Write port 0 carries in-order writeback; write port 1 carries late results
// and also retires the busy bit of its target. Issue logic reserves a
// register with rsv_en and stalls while rd_busy is set for a source operand.
// There are no valid/ready handshakes here: every enable is a single-cycle
// strobe acted on at the next rising clock edge.
module register_file_sb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter bit BYPASS         = 1'b1,
  parameter bit ZERO_REG       = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  input  logic                                 wr0_en,
  input  logic [ADDR_WIDTH-1:0]                wr0_addr,
  input  logic [DATA_WIDTH-1:0]                wr0_data,
  input  logic                                 wr1_en,
  input  logic [ADDR_WIDTH-1:0]                wr1_addr,
  input  logic [DATA_WIDTH-1:0]                wr1_data,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  input  logic                                 flush,
  output logic [ADDR_WIDTH:0]                  busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Storage update: wr1 is applied first so wr0 overrides it on an address tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr1_en && !(ZERO_REG && wr1_addr == '0)) regs[wr1_addr] <= wr1_data;
      if (wr0_en && !(ZERO_REG && wr0_addr == '0)) regs[wr0_addr] <= wr0_data;
    end
  end

  // Next busy vector: flush beats reserve, reserve beats release.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush)
        busy_nxt[i] = 1'b0;
      else if (rsv_en && rsv_addr == ADDR_WIDTH'(i))
        busy_nxt[i] = 1'b1;
      else if (wr1_en && wr1_addr == ADDR_WIDTH'(i))
        busy_nxt[i] = 1'b0;
    end
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      count_nxt = count_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  // Busy vector and its count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  // Combinational read ports; outputs are forced to zero while reset is held
  // so a bypassed write cannot leak through during reset.
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] word;
    logic                  bsy;

    assign a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Data select: zero register, then bypass (wr0 over wr1), then storage.
    always_comb begin
      word = regs[a];
      bsy  = busy[a];
      if (BYPASS) begin
        if (wr0_en && wr0_addr == a)      word = wr0_data;
        else if (wr1_en && wr1_addr == a) word = wr1_data;
        if (wr1_en && wr1_addr == a)      bsy  = 1'b0;
      end
      if ((ZERO_REG && a == '0) || reset) begin
        word = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = word;
    assign rd_busy[p]                          = bsy;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb at default parameters (BYPASS=1,
// ZERO_REG=1, 2 read ports, 32 x 32-bit registers).
module tb_register_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  // clock / reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             wr0_en, wr1_en, rsv_en, flush;
  logic [AW-1:0]    wr0_addr, wr1_addr, rsv_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [AW:0]      busy_count;

  register_file_sb dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .busy_count (busy_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr0_en = 0; wr1_en = 0; rsv_en = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic do_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_en = 1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic do_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic do_rsv(input logic [AW-1:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask

  initial begin
    reset = 1; rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
    idle();
    // outputs are zero while reset is held, even with a write presented
    do_wr0(5'd2, 32'hFFFF_FFFF); set_rd(0, 5'd2);
    #3;
    check("rst_hold_bypass", port_data(0), 0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;

    // 1: every index reads zero and not busy after reset
    for (int i = 0; i < 32; i++) begin
      set_rd(0, AW'(i)); set_rd(1, AW'(31 - i));
      #1;
      check("rst_data0", port_data(0), 0);
      check("rst_data1", port_data(1), 0);
      check("rst_busy",  rd_busy, 0);
    end
    check("rst_count", busy_count, 0);
    tick();

    // 2: same-cycle bypass of wr0, then stored value
    do_wr0(5'd5, 32'hDEAD_BEEF); set_rd(0, 5'd5);
    #1; check("byp_wr0", port_data(0), 32'hDEAD_BEEF);
    tick(); idle();
    #1; check("stored_x5", port_data(0), 32'hDEAD_BEEF);

    // 3: wr0 beats wr1 on the same address; x0 stays zero
    do_wr0(5'd7, 32'd1); do_wr1(5'd7, 32'd2); set_rd(1, 5'd7);
    #1; check("byp_wr0_prio", port_data(1), 32'd1);
    tick(); idle();
    #1; check("x7_after", port_data(1), 32'd1);
    check("x7_busy", rd_busy[1], 0);
    do_wr0(5'd0, 32'h55); set_rd(0, 5'd0);
    #1; check("x0_byp", port_data(0), 0);
    tick(); idle();
    #1; check("x0_after", port_data(0), 0);

    // 4: reserve then release through wr1 with bypassed ready
    do_rsv(5'd3); set_rd(0, 5'd3);
    #1; check("rsv_not_same_cycle", rd_busy[0], 0);
    tick(); idle();
    #1; check("rsv_busy", rd_busy[0], 1);
    check("rsv_count", busy_count, 1);
    do_wr1(5'd3, 32'h1234);
    #1; check("rel_byp_busy", rd_busy[0], 0);
    check("rel_byp_data", port_data(0), 32'h1234);
    check("rel_count_same", busy_count, 1);
    tick(); idle();
    #1; check("rel_count", busy_count, 0);
    check("rel_busy", rd_busy[0], 0);
    check("rel_data", port_data(0), 32'h1234);

    // 5: reserve wins over release; flush overrides reserve
    do_rsv(5'd9); set_rd(0, 5'd9);
    tick(); idle();
    do_rsv(5'd9); do_wr1(5'd9, 32'hAA);
    tick(); idle();
    #1; check("rsv_rel_busy", rd_busy[0], 1);
    check("rsv_rel_count", busy_count, 1);
    check("rsv_rel_data", port_data(0), 32'hAA);
    do_wr0(5'd9, 32'hBB);
    tick(); idle();
    #1; check("wr0_no_release", rd_busy[0], 1);
    flush = 1; do_rsv(5'd10); set_rd(1, 5'd10);
    tick(); idle();
    #1; check("flush_count", busy_count, 0);
    check("flush_busy", rd_busy, 0);
    check("flush_data_kept", port_data(0), 32'hBB);

    // release of a non-busy register; reservation of x0 ignored
    do_wr1(5'd11, 32'h77); do_rsv(5'd0); set_rd(0, 5'd11); set_rd(1, 5'd0);
    tick(); idle();
    #1; check("nb_rel_data", port_data(0), 32'h77);
    check("nb_rel_busy", rd_busy, 0);
    check("x0_rsv_count", busy_count, 0);

    // double reservation counts once
    do_rsv(5'd12);
    tick(); do_rsv(5'd12);
    tick(); idle();
    #1; check("double_rsv_count", busy_count, 1);
    flush = 1;
    tick(); idle();

    // 6: asynchronous reset mid-cycle clears everything immediately
    do_rsv(5'd4);
    tick(); do_rsv(5'd6);
    tick(); idle();
    set_rd(0, 5'd4); set_rd(1, 5'd5);
    #1; check("pre_rst_count", busy_count, 2);
    check("pre_rst_busy", rd_busy[0], 1);
    #1; reset = 1;
    #1; check("async_count", busy_count, 0);
    check("async_busy", rd_busy, 0);
    check("async_data", port_data(1), 0);
    @(negedge clk); reset = 0;
    // late wr1 after reset writes data but leaves busy clear
    do_wr1(5'd4, 32'h99);
    tick(); idle();
    #1; check("late_wr1_data", port_data(0), 32'h99);
    check("late_wr1_busy", rd_busy[0], 0);
    check("late_wr1_count", busy_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
